// File: rtl/lcd_timing_pkg.sv
// Shared types, default panel constants (AT043TN25, 480x272) and phase decode
// for the LCD raster timing generator.
package lcd_timing_pkg;

  typedef enum logic [1:0] {
    PH_SYNC,
    PH_BP,
    PH_ACTIVE,
    PH_FP
  } phase_e;

  localparam int unsigned DEF_H_ACTIVE = 480;
  localparam int unsigned DEF_H_FP     = 0;
  localparam int unsigned DEF_H_SYNC   = 41;
  localparam int unsigned DEF_H_BP     = 4;
  localparam int unsigned DEF_V_ACTIVE = 272;
  localparam int unsigned DEF_V_FP     = 0;
  localparam int unsigned DEF_V_SYNC   = 10;
  localparam int unsigned DEF_V_BP     = 8;

  // Zero-length porches fall through naturally: their range is empty.
  function automatic phase_e phase_of(input int unsigned cnt,
                                      input int unsigned sync,
                                      input int unsigned bp,
                                      input int unsigned active);
    if (cnt < sync)                    return PH_SYNC;
    else if (cnt < sync + bp)          return PH_BP;
    else if (cnt < sync + bp + active) return PH_ACTIVE;
    else                               return PH_FP;
  endfunction

endpackage

// File: rtl/lcd_timing_axis.sv
// One raster axis: modulo-TOTAL counter with advance/wrap chaining and phase decode.
module lcd_timing_axis
  import lcd_timing_pkg::*;
#(
  parameter  int unsigned TOTAL  = 525,
  parameter  int unsigned SYNC   = DEF_H_SYNC,
  parameter  int unsigned BP     = DEF_H_BP,
  parameter  int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter  int unsigned INIT   = 0,
  localparam int unsigned CNT_W  = $clog2(TOTAL)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             adv_i,
  output logic [CNT_W-1:0] cnt_o,
  output phase_e           phase_o,
  output logic             wrap_o
);

  localparam logic [CNT_W-1:0] LAST   = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] INIT_V = CNT_W'(INIT);

  if (INIT >= TOTAL) begin : g_bad_init
    $error("lcd_timing_axis: INIT must be below TOTAL");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    wrap_o = adv_i && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (adv_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= INIT_V;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o   = cnt_q;
  assign phase_o = phase_of(32'(cnt_q), SYNC, BP, ACTIVE);

endmodule

// File: rtl/lcd_timing_gen.sv
// Parallel-RGB LCD raster timing generator: registered HSYNC/VSYNC/DE/pulses and
// active-area coordinates running LEAD cycles ahead of DE.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter  int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter  int unsigned H_FP     = DEF_H_FP,
  parameter  int unsigned H_SYNC   = DEF_H_SYNC,
  parameter  int unsigned H_BP     = DEF_H_BP,
  parameter  int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter  int unsigned V_FP     = DEF_V_FP,
  parameter  int unsigned V_SYNC   = DEF_V_SYNC,
  parameter  int unsigned V_BP     = DEF_V_BP,
  parameter  bit          SYNC_POL = 1'b0,
  parameter  int unsigned LEAD     = 1,
  localparam int unsigned COL_W    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
  localparam int unsigned ROW_W    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_de,
  output logic             o_line_start,
  output logic             o_frame_start,
  output logic [COL_W-1:0] o_col,
  output logic [ROW_W-1:0] o_row
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned H_OFF   = H_SYNC + H_BP;
  localparam int unsigned V_OFF   = V_SYNC + V_BP;
  localparam int unsigned HC_W    = $clog2(H_TOTAL);
  localparam int unsigned VC_W    = $clog2(V_TOTAL);

  if (H_ACTIVE == 0 || V_ACTIVE == 0 || H_SYNC == 0 || V_SYNC == 0) begin : g_bad_size
    $error("lcd_timing_gen: ACTIVE and SYNC widths must be non-zero");
  end
  if (LEAD >= H_TOTAL || LEAD > 7) begin : g_bad_lead
    $error("lcd_timing_gen: LEAD must be 0..7 and below H_TOTAL");
  end

  logic [HC_W-1:0] h_cnt, hla_cnt;
  logic [VC_W-1:0] v_cnt, vla_cnt;
  phase_e          h_ph, v_ph, hla_ph, vla_ph;
  logic            h_wrap, v_wrap, hla_wrap, vla_wrap;

  lcd_timing_axis #(
    .TOTAL(H_TOTAL), .SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .INIT(0)
  ) u_h_axis (
    .clk_i(i_clk), .rst_ni(i_rst_n), .adv_i(i_enable),
    .cnt_o(h_cnt), .phase_o(h_ph), .wrap_o(h_wrap)
  );

  lcd_timing_axis #(
    .TOTAL(V_TOTAL), .SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .INIT(0)
  ) u_v_axis (
    .clk_i(i_clk), .rst_ni(i_rst_n), .adv_i(h_wrap),
    .cnt_o(v_cnt), .phase_o(v_ph), .wrap_o(v_wrap)
  );

  // Look-ahead pair: same counters preset LEAD ahead, so the carry into the
  // row counter happens LEAD cycles early without any delay line.
  lcd_timing_axis #(
    .TOTAL(H_TOTAL), .SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .INIT(LEAD)
  ) u_hla_axis (
    .clk_i(i_clk), .rst_ni(i_rst_n), .adv_i(i_enable),
    .cnt_o(hla_cnt), .phase_o(hla_ph), .wrap_o(hla_wrap)
  );

  lcd_timing_axis #(
    .TOTAL(V_TOTAL), .SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .INIT(0)
  ) u_vla_axis (
    .clk_i(i_clk), .rst_ni(i_rst_n), .adv_i(hla_wrap),
    .cnt_o(vla_cnt), .phase_o(vla_ph), .wrap_o(vla_wrap)
  );

  logic unused_wraps;
  assign unused_wraps = &{1'b0, v_wrap, vla_wrap};

  logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d, ls_q, ls_d, fs_q, fs_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  always_comb begin
    hs_d  = (h_ph == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    vs_d  = (v_ph == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    de_d  = (h_ph == PH_ACTIVE) && (v_ph == PH_ACTIVE);
    ls_d  = (h_cnt == '0);
    fs_d  = (h_cnt == '0) && (v_cnt == '0);
    col_d = '0;
    row_d = '0;
    if (hla_ph == PH_ACTIVE) col_d = COL_W'(32'(hla_cnt) - H_OFF);
    if (vla_ph == PH_ACTIVE) row_d = ROW_W'(32'(vla_cnt) - V_OFF);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      de_q  <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
      col_q <= '0;
      row_q <= '0;
    end else if (i_enable) begin
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      de_q  <= de_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign o_hsync       = hs_q;
  assign o_vsync       = vs_q;
  assign o_de          = de_q;
  assign o_line_start  = ls_q;
  assign o_frame_start = fs_q;
  assign o_col         = col_q;
  assign o_row         = row_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Scoreboard bench: three configurations driven in lockstep, expected outputs
// computed arithmetically from the enabled-edge index since reset.
module tb_lcd_timing_gen;

  typedef struct packed {
    logic        hs, vs, de, ls, fs;
    logic [15:0] col, row;
  } obs_t;

  typedef struct packed {
    obs_t [2:0] o;
    int         k;
    logic       en;
    logic       rst;
  } ent_t;

  // dut0: small config, SYNC_POL=1, LEAD=3; dut1: zero porches; dut2: defaults
  localparam int HA[3]  = '{4, 6, 480};
  localparam int HF[3]  = '{1, 0, 0};
  localparam int HS[3]  = '{1, 2, 41};
  localparam int HB[3]  = '{2, 0, 4};
  localparam int VA[3]  = '{2, 3, 272};
  localparam int VF[3]  = '{1, 0, 0};
  localparam int VS[3]  = '{1, 1, 10};
  localparam int VB[3]  = '{1, 2, 8};
  localparam int POL[3] = '{1, 0, 0};
  localparam int LD[3]  = '{3, 1, 1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  always #5 clk = ~clk;

  logic       hs0, vs0, de0, ls0, fs0, hs1, vs1, de1, ls1, fs1, hs2, vs2, de2, ls2, fs2;
  logic [1:0] col0;
  logic [0:0] row0;
  logic [2:0] col1;
  logic [1:0] row1;
  logic [8:0] col2, row2;

  lcd_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(2),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1), .LEAD(3)
  ) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en),
    .o_hsync(hs0), .o_vsync(vs0), .o_de(de0), .o_line_start(ls0),
    .o_frame_start(fs0), .o_col(col0), .o_row(row0)
  );

  lcd_timing_gen #(
    .H_ACTIVE(6), .H_FP(0), .H_SYNC(2), .H_BP(0),
    .V_ACTIVE(3), .V_FP(0), .V_SYNC(1), .V_BP(2),
    .SYNC_POL(1'b0), .LEAD(1)
  ) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en),
    .o_hsync(hs1), .o_vsync(vs1), .o_de(de1), .o_line_start(ls1),
    .o_frame_start(fs1), .o_col(col1), .o_row(row1)
  );

  lcd_timing_gen u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en),
    .o_hsync(hs2), .o_vsync(vs2), .o_de(de2), .o_line_start(ls2),
    .o_frame_start(fs2), .o_col(col2), .o_row(row2)
  );

  function automatic obs_t rst_obs(input int d);
    obs_t o;
    o = '0;
    o.hs = ~POL[d][0];
    o.vs = ~POL[d][0];
    return o;
  endfunction

  // Output state after the enabled edge that samples counter state k.
  function automatic obs_t model(input int d, input int k);
    obs_t o;
    int ht, vt, hc, vc, la, hl, vl, h0, v0;
    ht = HS[d] + HB[d] + HA[d] + HF[d];
    vt = VS[d] + VB[d] + VA[d] + VF[d];
    h0 = HS[d] + HB[d];
    v0 = VS[d] + VB[d];
    hc = k % ht;
    vc = (k / ht) % vt;
    la = k + LD[d];
    hl = la % ht;
    vl = (la / ht) % vt;
    o.hs  = (hc < HS[d]) ? POL[d][0] : ~POL[d][0];
    o.vs  = (vc < VS[d]) ? POL[d][0] : ~POL[d][0];
    o.de  = (hc >= h0 && hc < h0 + HA[d]) && (vc >= v0 && vc < v0 + VA[d]);
    o.ls  = (hc == 0);
    o.fs  = (hc == 0) && (vc == 0);
    o.col = (hl >= h0 && hl < h0 + HA[d]) ? 16'(hl - h0) : 16'd0;
    o.row = (vl >= v0 && vl < v0 + VA[d]) ? 16'(vl - v0) : 16'd0;
    return o;
  endfunction

  function automatic obs_t actual(input int d);
    obs_t o;
    case (d)
      0:       o = '{hs0, vs0, de0, ls0, fs0, 16'(col0), 16'(row0)};
      1:       o = '{hs1, vs1, de1, ls1, fs1, 16'(col1), 16'(row1)};
      default: o = '{hs2, vs2, de2, ls2, fs2, 16'(col2), 16'(row2)};
    endcase
    return o;
  endfunction

  ent_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   kcnt = 0;
  int   stall_left = 0;
  bit   started = 1'b0;
  int   first_de_k = -1;
  int   fs_prev = -1;
  obs_t last[3];

  task automatic report(input string name, input int d, input obs_t a, input obs_t e);
    $display("FAIL %s dut%0d t=%0t got hs%b vs%b de%b ls%b fs%b col%0d row%0d required hs%b vs%b de%b ls%b fs%b col%0d row%0d",
             name, d, $time, a.hs, a.vs, a.de, a.ls, a.fs, a.col, a.row,
             e.hs, e.vs, e.de, e.ls, e.fs, e.col, e.row);
  endtask

  // Reference model step for the edge that just occurred.
  task automatic on_edge();
    ent_t e;
    e.en  = rst_n && en;
    e.rst = !rst_n;
    e.k   = kcnt;
    for (int d = 0; d < 3; d++) begin
      if (!rst_n)  last[d] = rst_obs(d);
      else if (en) last[d] = model(d, kcnt);
      e.o[d] = last[d];
    end
    if (!rst_n)  kcnt = 0;
    else if (en) kcnt++;
    sb.push_back(e);
    started = 1'b1;
  endtask

  task automatic pick_enable();
    if (stall_left > 0) begin
      en = 1'b0;
      stall_left--;
    end else if ($urandom_range(0, 39) == 0) begin
      en = 1'b0;
      stall_left = 4;
    end else begin
      en = ($urandom_range(0, 9) != 0);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    on_edge();
    #2 pick_enable();
  endtask

  initial begin : monitor
    ent_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      if (sb.size() == 0) begin
        if (started) begin
          n_chk++;
          n_fail++;
          $display("FAIL scoreboard_empty t=%0t got 0 entries required 1", $time);
        end
      end else begin
        e = sb.pop_front();
        if (e.rst) fs_prev = -1;
        for (int d = 0; d < 3; d++) begin
          a = actual(d);
          n_chk++;
          if (a !== e.o[d]) begin
            n_fail++;
            report("output_seq", d, a, e.o[d]);
          end
        end
        if (e.en && de2 && first_de_k < 0) first_de_k = e.k;
        if (e.en && fs0) begin
          if (fs_prev >= 0) begin
            n_chk++;
            if (e.k - fs_prev != 40) begin
              n_fail++;
              $display("FAIL frame_period dut0 got %0d required 40", e.k - fs_prev);
            end
          end
          fs_prev = e.k;
        end
      end
    end
  end

  initial begin : driver
    obs_t a;
    for (int d = 0; d < 3; d++) last[d] = rst_obs(d);
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) cyc();
    @(posedge clk);
    on_edge();
    #2;
    rst_n = 1'b1;
    en    = 1'b1;
    stall_left = 0;
    repeat (13000) cyc();

    // Asynchronous reset between edges, after this cycle's entry was checked.
    @(posedge clk);
    on_edge();
    #2 en = 1'b1;
    #5 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      a = actual(d);
      n_chk++;
      if (a !== rst_obs(d)) begin
        n_fail++;
        report("async_reset", d, a, rst_obs(d));
      end
    end
    repeat (2) cyc();
    @(posedge clk);
    on_edge();
    #2;
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (600) cyc();

    @(negedge clk);
    #1;
    n_chk++;
    if (first_de_k != 18 * 525 + 45) begin
      n_fail++;
      $display("FAIL first_de_rise dut2 got %0d required %0d", first_de_k, 18 * 525 + 45);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
